// File: rtl/eth_tx_frame_builder.sv
// Ethernet TX frame builder: prepends dest/src/type header to a payload stream and zero-pads short frames.
// Latency: first header byte is registered on the header-accept edge; payload bytes pass through one output register.
// Backpressure: m_axis_tready gates the output register; s_axis_tready is combinationally derived from it (no payload buffering).
//
// Ports:
//   clk, rst                      - rising-edge clock, synchronous active-high reset
//   s_hdr_*                       - header descriptor (destination MAC, EtherType) with valid/ready
//   s_axis_*                      - 8-bit payload stream with tlast and error flag (tuser)
//   m_axis_*                      - 8-bit frame stream; tuser is meaningful on the tlast beat only
//   local_mac                     - source MAC, sampled when the header is accepted
//   padding_enable                - pad short frames up to MIN_FRAME_LEN, sampled when the header is accepted
//   busy                          - frame in progress or output register still holding a beat
module eth_tx_frame_builder #(
    parameter int DATA_WIDTH     = 8,
    parameter bit ENABLE_PADDING = 1'b1,
    parameter int MIN_FRAME_LEN  = 60
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s_hdr_valid,
    output logic                  s_hdr_ready,
    input  logic [47:0]           s_hdr_dest_mac,
    input  logic [15:0]           s_hdr_type,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,

    input  logic [47:0]           local_mac,
    input  logic                  padding_enable,
    output logic                  busy
);

    localparam logic [6:0] MIN_LEN   = 7'(MIN_FRAME_LEN);
    localparam logic [3:0] HDR_LAST  = 4'd13;
    localparam logic [6:0] CNT_MAX   = 7'd127;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        PAD     = 2'd3
    } state_t;

    state_t      state;
    logic [47:0] dest_reg;
    logic [47:0] src_reg;
    logic [15:0] type_reg;
    logic [3:0]  hdr_idx;
    logic [6:0]  frame_cnt;
    logic        pad_en_reg;
    logic        tuser_latch;

    logic        out_en;
    logic [7:0]  hdr_byte;
    logic [6:0]  cnt_inc;
    logic        below_min;

    // The output register may load whenever it is empty or its beat is being taken.
    assign out_en        = !m_axis_tvalid || m_axis_tready;
    assign s_hdr_ready   = (state == IDLE);
    assign s_axis_tready = (state == PAYLOAD) && out_en;
    assign busy          = (state != IDLE) || m_axis_tvalid;

    // Saturating byte count including the byte being loaded this cycle.
    assign cnt_inc   = (frame_cnt == CNT_MAX) ? CNT_MAX : frame_cnt + 7'd1;
    // True while the byte being loaded still leaves the frame short of the minimum.
    assign below_min = (cnt_inc < MIN_LEN);

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx)
            4'd0:    hdr_byte = dest_reg[47:40];
            4'd1:    hdr_byte = dest_reg[39:32];
            4'd2:    hdr_byte = dest_reg[31:24];
            4'd3:    hdr_byte = dest_reg[23:16];
            4'd4:    hdr_byte = dest_reg[15:8];
            4'd5:    hdr_byte = dest_reg[7:0];
            4'd6:    hdr_byte = src_reg[47:40];
            4'd7:    hdr_byte = src_reg[39:32];
            4'd8:    hdr_byte = src_reg[31:24];
            4'd9:    hdr_byte = src_reg[23:16];
            4'd10:   hdr_byte = src_reg[15:8];
            4'd11:   hdr_byte = src_reg[7:0];
            4'd12:   hdr_byte = type_reg[15:8];
            4'd13:   hdr_byte = type_reg[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dest_reg      <= '0;
            src_reg       <= '0;
            type_reg      <= '0;
            hdr_idx       <= '0;
            frame_cnt     <= '0;
            pad_en_reg    <= 1'b0;
            tuser_latch   <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_en) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                    end
                    if (s_hdr_valid) begin
                        dest_reg    <= s_hdr_dest_mac;
                        src_reg     <= local_mac;
                        type_reg    <= s_hdr_type;
                        pad_en_reg  <= padding_enable && ENABLE_PADDING;
                        tuser_latch <= 1'b0;
                        state       <= HEADER;
                        // Loading the first destination byte straight from the
                        // descriptor on the accept edge avoids a bubble between
                        // back-to-back frames.
                        if (out_en) begin
                            m_axis_tdata  <= s_hdr_dest_mac[47:40];
                            m_axis_tvalid <= 1'b1;
                            hdr_idx       <= 4'd1;
                            frame_cnt     <= 7'd1;
                        end else begin
                            hdr_idx       <= 4'd0;
                            frame_cnt     <= 7'd0;
                        end
                    end
                end

                HEADER: begin
                    if (out_en) begin
                        m_axis_tdata  <= hdr_byte;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                        frame_cnt     <= cnt_inc;
                        hdr_idx       <= hdr_idx + 4'd1;
                        if (hdr_idx == HDR_LAST) begin
                            state <= PAYLOAD;
                        end
                    end
                end

                PAYLOAD: begin
                    if (out_en) begin
                        if (s_axis_tvalid) begin
                            m_axis_tdata  <= s_axis_tdata;
                            m_axis_tvalid <= 1'b1;
                            frame_cnt     <= cnt_inc;
                            tuser_latch   <= tuser_latch | s_axis_tuser;
                            if (s_axis_tlast && !(pad_en_reg && below_min)) begin
                                m_axis_tlast <= 1'b1;
                                m_axis_tuser <= tuser_latch | s_axis_tuser;
                                state        <= IDLE;
                            end else begin
                                m_axis_tlast <= 1'b0;
                                m_axis_tuser <= 1'b0;
                                if (s_axis_tlast) begin
                                    state <= PAD;
                                end
                            end
                        end else begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tuser  <= 1'b0;
                        end
                    end
                end

                PAD: begin
                    if (out_en) begin
                        m_axis_tdata  <= '0;
                        m_axis_tvalid <= 1'b1;
                        frame_cnt     <= cnt_inc;
                        if (!below_min) begin
                            m_axis_tlast <= 1'b1;
                            m_axis_tuser <= tuser_latch;
                            state        <= IDLE;
                        end else begin
                            m_axis_tlast <= 1'b0;
                            m_axis_tuser <= 1'b0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_builder.sv
module tb_eth_tx_frame_builder;

    localparam int MIN_LEN = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_hdr_valid = 1'b0;
    logic        s_hdr_ready;
    logic [47:0] s_hdr_dest_mac = '0;
    logic [15:0] s_hdr_type = '0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [47:0] local_mac = '0;
    logic        padding_enable = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    eth_tx_frame_builder #(
        .DATA_WIDTH(8), .ENABLE_PADDING(1'b1), .MIN_FRAME_LEN(MIN_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_hdr_dest_mac(s_hdr_dest_mac), .s_hdr_type(s_hdr_type),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .local_mac(local_mac), .padding_enable(padding_enable), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] typ;
        bit          pad;
    } hdr_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    beat_t drv_q[$];
    hdr_t  hdr_q[$];

    logic [7:0] pay [256];
    bit         puser [256];

    int checks = 0;
    int errors = 0;
    int stall_viol = 0;
    int hdr_viol = 0;
    bit rand_ready = 1'b0;

    // Output monitor: collects transferred beats and watches protocol rules.
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dat;
    logic       prev_last;
    logic       prev_user;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_dat ||
                               m_axis_tlast !== prev_last || m_axis_tuser !== prev_user))
                stall_viol++;
            // A non-last beat in the output register means the frame's last byte is
            // not loaded yet, so a new header must not be accepted.
            if (s_hdr_ready && ((m_axis_tvalid && !m_axis_tlast) || s_axis_tready))
                hdr_viol++;
            if (m_axis_tvalid && m_axis_tready)
                got_q.push_back('{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser});
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_dat   = m_axis_tdata;
            prev_last  = m_axis_tlast;
            prev_user  = m_axis_tuser;
        end
    end

    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference model: queues one frame's descriptor and payload, and the exact
    // byte stream an Ethernet frame of that content must produce.
    function automatic void add_frame(input int n, input logic [47:0] dest, input logic [47:0] src,
                                      input logic [15:0] typ, input bit pad);
        logic [111:0] hv;
        int          total;
        bit          err;
        logic [7:0]  b;
        hdr_t        h;
        h.dest = dest; h.src = src; h.typ = typ; h.pad = pad;
        hdr_q.push_back(h);
        hv  = {dest, src, typ};
        err = 1'b0;
        for (int i = 0; i < n; i++) begin
            drv_q.push_back('{d: pay[i], l: (i == n - 1), u: puser[i]});
            err |= puser[i];
        end
        total = 14 + n;
        if (pad && total < MIN_LEN) total = MIN_LEN;
        for (int i = 0; i < total; i++) begin
            if (i < 14)          b = hv[111 - 8*i -: 8];
            else if (i < 14 + n) b = pay[i - 14];
            else                 b = 8'h00;
            exp_q.push_back('{d: b, l: (i == total - 1), u: (i == total - 1) && err});
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_headers(input int count);
        hdr_t h;
        bit   acc;
        for (int k = 0; k < count; k++) begin
            h = hdr_q.pop_front();
            s_hdr_dest_mac = h.dest;
            s_hdr_type     = h.typ;
            local_mac      = h.src;
            padding_enable = h.pad;
            s_hdr_valid    = 1'b1;
            acc = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                acc = s_hdr_ready;
                step();
                if (acc) break;
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL hdr_accept_timeout frame %0d: s_hdr_ready never seen, required within 3000 cycles", k);
            end
            // Descriptor only needs to hold during the handshake cycle.
            s_hdr_valid    = 1'b0;
            s_hdr_dest_mac = 48'({$urandom(), $urandom()});
            s_hdr_type     = 16'($urandom());
            local_mac      = 48'({$urandom(), $urandom()});
            padding_enable = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive_payload(input int count, input bit gaps);
        beat_t b;
        bit    acc;
        for (int k = 0; k < count; k++) begin
            b = drv_q.pop_front();
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                step();
            end
            s_axis_tdata  = b.d;
            s_axis_tlast  = b.l;
            s_axis_tuser  = b.u;
            s_axis_tvalid = 1'b1;
            acc = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                acc = s_axis_tready;
                step();
                if (acc) break;
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL payload_timeout beat %0d: s_axis_tready never seen, required within 3000 cycles", k);
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic wait_out(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        repeat (4) step();
    endtask

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
        drv_q.delete();
        hdr_q.delete();
        for (int i = 0; i < 256; i++) puser[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser got %b want 0", m_axis_tuser); end
        checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata got %h want 00", m_axis_tdata); end
        checks++; if (s_hdr_ready !== 1'b1) begin errors++; $display("FAIL rst_hdr_ready got %b want 1", s_hdr_ready); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_axis_tready got %b want 0", s_axis_tready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        rst = 1'b0;
        step();
    endtask

    // 50-byte payload: 64-byte frame, no padding, first byte right after accept.
    task automatic test_long_frame();
        bit    ok;
        beat_t g;
        clear_queues();
        for (int i = 0; i < 50; i++) pay[i] = 8'(i);
        add_frame(50, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 1'b1);
        drive_headers(1);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hFF) begin
            errors++;
            $display("FAIL t1_first_byte got valid=%b data=%h want valid=1 data=ff", m_axis_tvalid, m_axis_tdata);
        end
        drive_payload(50, 1'b0);
        wait_out(exp_q.size(), 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t1_timeout got %0d beats want %0d", got_q.size(), exp_q.size()); end
        checks++; if (got_q.size() != 64) begin errors++; $display("FAIL t1_len got %0d want 64", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL t1_byte%0d got d=%h l=%b u=%b want d=%h l=%b u=%b", i, g.d, g.l, g.u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after got %b want 0", busy); end
    endtask

    // 4-byte payload with and without padding.
    task automatic test_short_frame(input bit pad);
        bit    ok;
        int    padrdy;
        int    want_len;
        beat_t g;
        clear_queues();
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD;
        want_len = pad ? 60 : 18;
        add_frame(4, 48'h0011_2233_4455, 48'h0200_0000_0001, 16'h88B5, pad);
        drive_headers(1);
        drive_payload(4, 1'b0);
        padrdy = 0;
        for (int c = 0; c < 200 && got_q.size() < exp_q.size(); c++) begin
            @(negedge clk);
            if (s_axis_tready) padrdy++;
        end
        wait_out(exp_q.size(), 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL short_timeout pad=%0d got %0d beats want %0d", pad, got_q.size(), exp_q.size()); end
        checks++; if (padrdy != 0) begin errors++; $display("FAIL short_pad_tready pad=%0d got %0d ready cycles want 0", pad, padrdy); end
        checks++; if (got_q.size() != want_len) begin errors++; $display("FAIL short_len pad=%0d got %0d want %0d", pad, got_q.size(), want_len); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL short_byte%0d pad=%0d got d=%h l=%b u=%b want d=%h l=%b u=%b", i, pad, g.d, g.l, g.u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
            end
        end
    endtask

    // Error flag on one mid-payload byte must surface on the final pad beat only.
    task automatic test_tuser();
        bit    ok;
        beat_t g;
        clear_queues();
        for (int i = 0; i < 10; i++) pay[i] = 8'($urandom());
        puser[3] = 1'b1;
        add_frame(10, 48'h0A0B_0C0D_0E0F, 48'h0200_0000_0002, 16'h86DD, 1'b1);
        drive_headers(1);
        drive_payload(10, 1'b0);
        wait_out(exp_q.size(), 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t4_timeout got %0d beats want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL t4_byte%0d got d=%h l=%b u=%b want d=%h l=%b u=%b", i, g.d, g.l, g.u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
            end
        end
    endtask

    // Three back-to-back frames under random output backpressure.
    task automatic test_back_to_back();
        bit    ok;
        beat_t g;
        int    sizes [3];
        int    lasts;
        sizes[0] = 1; sizes[1] = 46; sizes[2] = 200;
        clear_queues();
        stall_viol = 0;
        hdr_viol   = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < sizes[f]; i++) begin
                pay[i]   = 8'($urandom());
                puser[i] = ($urandom_range(0, 39) == 0);
            end
            add_frame(sizes[f], 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
                      16'($urandom()), 1'b1);
        end
        rand_ready = 1'b1;
        fork
            drive_headers(3);
            drive_payload(247, 1'b1);
        join
        wait_out(exp_q.size(), 5000, ok);
        rand_ready = 1'b0;
        repeat (3) step();
        checks++; if (!ok) begin errors++; $display("FAIL t5_timeout got %0d beats want %0d", got_q.size(), exp_q.size()); end
        checks++; if (got_q.size() != 334) begin errors++; $display("FAIL t5_total_len got %0d want 334", got_q.size()); end
        lasts = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            if (g.l) lasts++;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL t5_byte%0d got d=%h l=%b u=%b want d=%h l=%b u=%b", i, g.d, g.l, g.u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
            end
        end
        checks++; if (lasts != 3) begin errors++; $display("FAIL t5_tlast_count got %0d want 3", lasts); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL t5_stall_stable got %0d changes want 0", stall_viol); end
        checks++; if (hdr_viol != 0) begin errors++; $display("FAIL t5_hdr_ready_idle got %0d violations want 0", hdr_viol); end
    endtask

    // Reset in the middle of a payload, then a clean frame.
    task automatic test_mid_reset();
        bit    ok;
        beat_t g;
        clear_queues();
        for (int i = 0; i < 20; i++) pay[i] = 8'($urandom());
        add_frame(20, 48'h1122_3344_5566, 48'h0200_0000_0003, 16'h0806, 1'b1);
        drive_headers(1);
        drive_payload(5, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pay[5];
        rst = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t6_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy got %b want 0", busy); end
        checks++; if (s_hdr_ready !== 1'b1) begin errors++; $display("FAIL t6_hdr_ready got %b want 1", s_hdr_ready); end
        rst = 1'b0;
        step();
        clear_queues();
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom());
        add_frame(8, 48'h0102_0304_0506, 48'h0200_0000_0004, 16'h0800, 1'b1);
        drive_headers(1);
        drive_payload(8, 1'b0);
        wait_out(exp_q.size(), 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t6_timeout got %0d beats want %0d", got_q.size(), exp_q.size()); end
        checks++; if (got_q.size() != 60) begin errors++; $display("FAIL t6_len got %0d want 60", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL t6_byte%0d got d=%h l=%b u=%b want d=%h l=%b u=%b", i, g.d, g.l, g.u, exp_q[i].d, exp_q[i].l, exp_q[i].u);
            end
        end
    endtask

    initial begin
        test_reset();
        test_long_frame();
        test_short_frame(1'b1);
        test_short_frame(1'b0);
        test_tuser();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_frame_builder.md
Name: eth_tx_frame_builder

Overview:
Transmit-side counterpart to the receive-path frame filter. It takes a header descriptor (destination MAC, EtherType) and a payload AXI Stream. It emits a complete Ethernet frame without FCS: 14-byte header (dest MAC, local source MAC, EtherType), then the payload, then zero padding up to the minimum length. It sits between the TX protocol logic and the MAC FCS/preamble stage.

Parameters:
DATA_WIDTH, 8, stream width in bits; only 8 is supported.
ENABLE_PADDING, 1, when 0 the pad logic is removed and padding_enable is ignored.
MIN_FRAME_LEN, 60, minimum output frame length in bytes, header included and FCS excluded; legal range 15..127.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_hdr_valid  in  1  header descriptor valid
s_hdr_ready  out  1  header descriptor accepted when valid&ready
s_hdr_dest_mac  in  48  destination MAC, [47:40] sent first
s_hdr_type  in  16  EtherType/length, [15:8] sent first
s_axis_tdata  in  8  payload byte
s_axis_tvalid  in  1  payload valid
s_axis_tready  out  1  payload ready
s_axis_tlast  in  1  last payload byte
s_axis_tuser  in  1  payload error flag
m_axis_tdata  out  8  frame byte
m_axis_tvalid  out  1  frame valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last frame byte
m_axis_tuser  out  1  frame error, meaningful on the tlast beat only
local_mac  in  48  source MAC inserted in bytes 6..11
padding_enable  in  1  pad short frames to MIN_FRAME_LEN
busy  out  1  frame in progress

Behaviour:
- Reset (rst=1 at a clock edge):
  - m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0, state=IDLE, counters=0.
  - s_hdr_ready and s_axis_tready follow state: 1 and 0 respectively after reset.
  - Reset mid-frame aborts the frame with no tlast emitted; the upstream must also be reset.
- Output register: m_axis_* driven from registers.
  - Reg loads when out_en = !m_axis_tvalid || m_axis_tready.
  - m_axis_tvalid clears when out_en and nothing to load.
  - Data is stable while tvalid && !tready.
- Byte counter frame_cnt: 7 bits, counts output bytes loaded, saturates at 127, cleared on header accept.
- States:
  - IDLE:
    - s_hdr_ready=1 and s_axis_tready=0.
    - On s_hdr_valid: latch dest, type, local_mac and padding_enable (all sampled on this cycle); pad_en_reg = padding_enable && ENABLE_PADDING.
    - Clear the tuser latch; go to HEADER.
  - HEADER:
    - s_hdr_ready=0 and s_axis_tready=0.
    - On each out_en, load header byte hdr_idx: 0-5 dest, 6-11 src, 12-13 type; tlast=0.
    - After idx 13 go to PAYLOAD.
    - First header byte appears on m_axis one cycle after header accept.
  - PAYLOAD:
    - s_axis_tready = out_en; each accepted byte is loaded to output the same edge.
    - tuser_latch |= s_axis_tuser.
    - On the accepted tlast byte:
      - if pad_en_reg && frame_cnt+1 < MIN_FRAME_LEN: output tlast=0, go to PAD;
      - else output tlast=1, tuser=tuser_latch|s_axis_tuser, go to IDLE.
  - PAD:
    - s_axis_tready=0; on out_en load 0x00.
    - The byte making frame_cnt reach MIN_FRAME_LEN has tlast=1 and tuser=tuser_latch; then go to IDLE.
- Header acceptance: a new header can be accepted the cycle after the last byte is loaded into the output reg, giving back-to-back frames with no idle output beat when m_axis_tready=1.
- Zero-length payloads are not supported; each frame requires at least one payload beat with tlast.
- The header descriptor must stay stable only during its valid&ready cycle.
- busy = (state != IDLE) || m_axis_tvalid.
- Throughput: 1 byte/cycle sustained with m_axis_tready=1. Frame length = 14 + payload, or MIN_FRAME_LEN if padded.
- Backpressure on m_axis propagates combinationally to s_axis_tready (via out_en). There is no payload buffering beyond the output register.

Test Plan:
1. dest=FF:FF:FF:FF:FF:FF, local_mac=02:00:00:00:00:01, type=0x0800, 50-byte payload 0x00..0x31, padding on, tready=1 -> 64 bytes out: FF×6, 02 00 00 00 00 01, 08 00, payload; tlast on byte 63; no pad; first byte 1 cycle after hdr accept.
2. 4-byte payload AA BB CC DD, padding_enable=1 -> 60 bytes: header, AA BB CC DD, 42×0x00; tlast only on byte 59; s_axis_tready=0 during pad.
3. Same as 2 with padding_enable=0 -> 18 bytes, tlast on byte 17.
4. 10-byte payload with tuser=1 on byte 3 only, padding on -> 60-byte frame; m_axis_tuser=1 on the final pad beat and 0 elsewhere.
5. Random m_axis_tready (50%) over 3 back-to-back frames of 1, 46 and 200 payload bytes -> byte streams exactly match the model, lengths 60/60/214, no data change while stalled, s_hdr_ready only in IDLE.
6. rst asserted at payload byte 5 -> next cycle m_axis_tvalid=0, busy=0, s_hdr_ready=1. After reset, a new 60-byte frame is emitted correctly.
